flow_ctrl_fsm: RTL and testbench
================================

FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Parameters
REQ-001 SHALL have parameter NUM_FIFOS, default 5: number of monitored FIFOs, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 3: width of each FIFO occupancy count and threshold.

Interface
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as below:
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  start / re-init request, level-sampled.
- fifo_error  in  NUM_FIFOS  per-FIFO error flags.
- fifo_empty  in  NUM_FIFOS  per-FIFO empty flags.
- fifo_count  in  NUM_FIFOS*CNT_W  packed occupancy; FIFO i at bits [i*CNT_W +: CNT_W].
- af_thr  in  CNT_W  almost-full threshold.
- ae_thr  in  CNT_W  almost-empty threshold.
- state_out  out  5  one-hot state: RESET=1, INIT=2, IDLE=4, ACTIVE=8, ERROR=16.
- error_out  out  NUM_FIFOS  sticky captured error mask.
- cfg_err  out  1  threshold configuration error.
- idle_out  out  1  high in IDLE.
- active_out  out  1  high in ACTIVE.
- pause_out  out  NUM_FIFOS  per-FIFO backpressure.

Function
REQ-004 All outputs SHALL be registered; each output reflects the state and registers after the same clk edge.
REQ-005 RESET: SHALL go to INIT on the first edge with init=1; otherwise SHALL stay in RESET.
REQ-006 INIT SHALL last exactly one cycle and SHALL latch af_thr and ae_thr into internal registers.
- If ae_thr >= af_thr: SHALL go to ERROR and set cfg_err=1.
- Otherwise: SHALL clear cfg_err and error_out, then go to IDLE.
REQ-007 Latched thresholds SHALL NOT change outside INIT, regardless of the af_thr and ae_thr inputs.
REQ-008 IDLE and ACTIVE: decision priority SHALL be as follows.
- Any fifo_error bit set: SHALL go to ERROR and load error_out with fifo_error.
- Otherwise, all fifo_empty bits set: SHALL go to IDLE.
- Otherwise: SHALL go to ACTIVE.
REQ-009 ERROR: error_out SHALL OR in every fifo_error sample each cycle (sticky accumulation).
REQ-010 ERROR SHALL be left only via init=1, which goes to INIT; init SHALL be ignored in IDLE and ACTIVE.
REQ-011 idle_out SHALL be 1 only in IDLE and active_out SHALL be 1 only in ACTIVE; both are mutually exclusive and SHALL be 0 in RESET, INIT and ERROR.
REQ-012 pause_out[i] SHALL use hysteresis in IDLE and ACTIVE, with comparisons unsigned on CNT_W bits:
- Set when count_i >= latched af.
- Cleared when count_i <= latched ae.
- Otherwise held.
REQ-013 pause_out SHALL be forced to all-ones in ERROR and to 0 in RESET and INIT.
REQ-014 Count and threshold arithmetic SHALL be exactly CNT_W bits, with no extension or wrap.
REQ-015 If fifo_error and a state change coincide in IDLE or ACTIVE, ERROR SHALL win.
REQ-016 If init=1 and fifo_error is non-zero in ERROR, INIT SHALL win; error_out SHALL clear one cycle later, in INIT.
REQ-017 Unreachable state encodings SHALL recover to RESET on the next edge.

Reset
REQ-018 reset_L=0 SHALL immediately (asynchronously) force the following values:
- state_out=RESET (1).
- error_out=0, cfg_err=0, idle_out=0, active_out=0, pause_out=0.
- Latched thresholds: af = all-ones, ae = 0.
REQ-019 Reset asserted mid-operation in any state SHALL abort to RESET with the REQ-018 values; release SHALL be glitch-free, with no transition on the release edge unless init=1 is sampled.

Verification
REQ-020 The bench SHALL cover these directed scenarios (NUM_FIFOS=5, CNT_W=3):
- V1: reset, then init=1 with af=6, ae=2 -> state 1 -> 2 -> 4 on consecutive edges; idle_out=1.
- V2: in IDLE, fifo_empty=5'b11110 -> next edge ACTIVE, active_out=1; fifo_empty=5'b11111 -> back to IDLE.
- V3: in ACTIVE, fifo_error=5'b00100 -> ERROR with error_out=5'b00100; later fifo_error=5'b00001 -> error_out=5'b00101; pause_out=5'b11111.
- V4: FIFO0 count sweep 0, 5, 6, 4, 3, 2, 0 (af=6, ae=2) -> pause_out[0] = 0, 0, 1, 1, 1, 0, 0.
- V5: init with af=3, ae=3 -> ERROR with cfg_err=1; then init with af=6, ae=1 -> INIT, then IDLE, cfg_err=0.
- V6: reset_L pulsed low mid-cycle in ACTIVE -> outputs reach REQ-018 values before the next clk edge.

Source files
------------

// File: rtl/flow_ctrl_fsm.sv
// Flow-control sequencer: watches a bank of FIFOs, applies per-FIFO hysteresis
// backpressure and captures error flags until software re-initialises.
//
// state  | meaning
// RESET  | waiting for init after reset
// INIT   | one cycle: latch thresholds, validate them
// IDLE   | all FIFOs empty, no errors
// ACTIVE | at least one FIFO non-empty, no errors
// ERROR  | error or bad config captured; only init leaves
module flow_ctrl_fsm #(
  parameter int NUM_FIFOS = 5,
  parameter int CNT_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       init,
  input  logic [NUM_FIFOS-1:0]       fifo_error,
  input  logic [NUM_FIFOS-1:0]       fifo_empty,
  input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
  input  logic [CNT_W-1:0]           af_thr,
  input  logic [CNT_W-1:0]           ae_thr,
  output logic [4:0]                 state_out,
  output logic [NUM_FIFOS-1:0]       error_out,
  output logic                       cfg_err,
  output logic                       idle_out,
  output logic                       active_out,
  output logic [NUM_FIFOS-1:0]       pause_out
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_FIFOS-1:0] error_q, error_d;
  logic [NUM_FIFOS-1:0] pause_q, pause_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 idle_q, active_q;
  logic [CNT_W-1:0]     af_q, af_d;
  logic [CNT_W-1:0]     ae_q, ae_d;

  // Set at/above almost-full, clear at/below almost-empty, otherwise hold.
  function automatic logic [NUM_FIFOS-1:0] hyst(
    input logic [NUM_FIFOS-1:0]       held,
    input logic [CNT_W-1:0]           af,
    input logic [CNT_W-1:0]           ae,
    input logic [NUM_FIFOS*CNT_W-1:0] cnt
  );
    logic [NUM_FIFOS-1:0] p;
    logic [CNT_W-1:0]     c;
    p = held;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      c = cnt[i*CNT_W +: CNT_W];
      if (c >= af)      p[i] = 1'b1;
      else if (c <= ae) p[i] = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    pause_d   = pause_q;
    cfg_err_d = cfg_err_q;
    af_d      = af_q;
    ae_d      = ae_q;
    case (state_q)
      ST_RESET: begin
        pause_d = '0;
        if (init) state_d = ST_INIT;
      end
      ST_INIT: begin
        af_d = af_thr;
        ae_d = ae_thr;
        if (ae_thr >= af_thr) begin
          state_d   = ST_ERROR;
          cfg_err_d = 1'b1;
          pause_d   = '1;
        end else begin
          state_d   = ST_IDLE;
          cfg_err_d = 1'b0;
          error_d   = '0;
          // First IDLE cycle already honours the thresholds being latched now.
          pause_d   = hyst('0, af_thr, ae_thr, fifo_count);
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (|fifo_error) begin
          state_d = ST_ERROR;
          error_d = fifo_error;
          pause_d = '1;
        end else begin
          state_d = (&fifo_empty) ? ST_IDLE : ST_ACTIVE;
          pause_d = hyst(pause_q, af_q, ae_q, fifo_count);
        end
      end
      ST_ERROR: begin
        if (init) begin
          state_d = ST_INIT;
          pause_d = '0;
        end else begin
          error_d = error_q | fifo_error;
          pause_d = '1;
        end
      end
      default: begin
        state_d   = ST_RESET;
        pause_d   = '0;
        error_d   = '0;
        cfg_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_RESET;
      error_q   <= '0;
      pause_q   <= '0;
      cfg_err_q <= 1'b0;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      af_q      <= '1;
      ae_q      <= '0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      pause_q   <= pause_d;
      cfg_err_q <= cfg_err_d;
      idle_q    <= (state_d == ST_IDLE);
      active_q  <= (state_d == ST_ACTIVE);
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  assign state_out  = state_q;
  assign error_out  = error_q;
  assign cfg_err    = cfg_err_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign pause_out  = pause_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Testbench for flow_ctrl_fsm: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the controller.
module tb_flow_ctrl_fsm;
  localparam int N = 5;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         init = 1'b0;
  logic [N-1:0] fifo_error = '0;
  logic [N-1:0] fifo_empty = '1;
  logic [N*W-1:0] fifo_count = '0;
  logic [W-1:0] af_thr = '0;
  logic [W-1:0] ae_thr = '0;
  logic [4:0]   state_out;
  logic [N-1:0] error_out;
  logic         cfg_err;
  logic         idle_out;
  logic         active_out;
  logic [N-1:0] pause_out;

  flow_ctrl_fsm #(.NUM_FIFOS(N), .CNT_W(W)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .fifo_error(fifo_error), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .af_thr(af_thr), .ae_thr(ae_thr),
    .state_out(state_out), .error_out(error_out), .cfg_err(cfg_err),
    .idle_out(idle_out), .active_out(active_out), .pause_out(pause_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR; state_out is 1<<phase.
  int           m_st;
  logic [N-1:0] m_err;
  logic [N-1:0] m_pause;
  bit           m_cfg;
  int           m_af;
  int           m_ae;

  function automatic void model_reset();
    m_st = 0; m_err = '0; m_pause = '0; m_cfg = 0; m_af = 7; m_ae = 0;
  endfunction

  function automatic void apply_hyst();
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(fifo_count[i*W +: W]);
      if (c >= m_af)      m_pause[i] = 1'b1;
      else if (c <= m_ae) m_pause[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    case (m_st)
      0: if (init) m_st = 1;
      1: begin
        m_af = int'(af_thr);
        m_ae = int'(ae_thr);
        if (m_ae >= m_af) begin
          m_st = 4; m_cfg = 1; m_pause = '1;
        end else begin
          m_st = 2; m_cfg = 0; m_err = '0; m_pause = '0;
          apply_hyst();
        end
      end
      2, 3: begin
        if (fifo_error != 0) begin
          m_st = 4; m_err = fifo_error; m_pause = '1;
        end else begin
          m_st = (fifo_empty == '1) ? 2 : 3;
          apply_hyst();
        end
      end
      4: begin
        if (init) begin
          m_st = 1; m_pause = '0;
        end else begin
          m_err = m_err | fifo_error;
        end
      end
      default: m_st = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_L = 1'b0;
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    init = 1'b0;
    apply_reset();
    n_tests++;
    if (state_out !== 5'b00001) begin n_fail++; $display("FAIL reset_state: got %b want 00001", state_out); end
    n_tests++;
    if ({error_out, cfg_err, idle_out, active_out, pause_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: err=%b cfg=%b idle=%b act=%b pause=%b want all 0",
                         error_out, cfg_err, idle_out, active_out, pause_out);
    end
    tick();
    n_tests++;
    if (state_out !== 5'b00001) begin n_fail++; $display("FAIL reset_hold: got %b want 00001", state_out); end
  endtask

  task automatic test_init_seq();
    fifo_empty = '1; fifo_error = '0; fifo_count = '0;
    af_thr = 3'd6; ae_thr = 3'd2; init = 1'b1;
    tick();
    n_tests++;
    if (state_out !== 5'b00010) begin n_fail++; $display("FAIL init_enter: got %b want 00010", state_out); end
    tick();
    init = 1'b0;
    n_tests++;
    if (state_out !== 5'b00100 || idle_out !== 1'b1 || active_out !== 1'b0) begin
      n_fail++; $display("FAIL init_to_idle: state=%b idle=%b act=%b want 00100/1/0", state_out, idle_out, active_out);
    end
  endtask

  task automatic test_idle_active();
    fifo_empty = 5'b11110;
    tick();
    n_tests++;
    if (state_out !== 5'b01000 || active_out !== 1'b1 || idle_out !== 1'b0) begin
      n_fail++; $display("FAIL idle_to_active: state=%b act=%b idle=%b want 01000/1/0", state_out, active_out, idle_out);
    end
    fifo_empty = 5'b11111;
    tick();
    n_tests++;
    if (state_out !== 5'b00100 || idle_out !== 1'b1) begin
      n_fail++; $display("FAIL active_to_idle: state=%b idle=%b want 00100/1", state_out, idle_out);
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    n_tests++;
    if (state_out !== 5'b00100) begin n_fail++; $display("FAIL init_ignored_idle: got %b want 00100", state_out); end
  endtask

  task automatic test_pause_hyst();
    int          sweep [7] = '{0, 5, 6, 4, 3, 2, 0};
    logic        expp  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fifo_empty = 5'b11110;
    af_thr = 3'd1; ae_thr = 3'd0;  // must not affect the latched 6/2
    for (int k = 0; k < 7; k++) begin
      fifo_count[W-1:0] = W'(sweep[k]);
      tick();
      n_tests++;
      if (pause_out[0] !== expp[k] || pause_out[N-1:1] !== '0) begin
        n_fail++; $display("FAIL pause_sweep[%0d] count=%0d: pause=%b want bit0=%b others 0",
                           k, sweep[k], pause_out, expp[k]);
      end
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    n_tests++;
    if (state_out !== 5'b01000) begin n_fail++; $display("FAIL init_ignored_active: got %b want 01000", state_out); end
  endtask

  task automatic test_error_sticky();
    fifo_error = 5'b00100;
    tick();
    n_tests++;
    if (state_out !== 5'b10000 || error_out !== 5'b00100 || pause_out !== 5'b11111 || active_out !== 1'b0) begin
      n_fail++; $display("FAIL error_enter: state=%b err=%b pause=%b act=%b want 10000/00100/11111/0",
                         state_out, error_out, pause_out, active_out);
    end
    fifo_error = 5'b00001;
    tick();
    n_tests++;
    if (error_out !== 5'b00101) begin n_fail++; $display("FAIL error_accum: got %b want 00101", error_out); end
    fifo_error = 5'b00000;
    tick();
    n_tests++;
    if (state_out !== 5'b10000 || error_out !== 5'b00101 || pause_out !== 5'b11111) begin
      n_fail++; $display("FAIL error_hold: state=%b err=%b pause=%b want 10000/00101/11111", state_out, error_out, pause_out);
    end
  endtask

  task automatic test_cfg_err();
    af_thr = 3'd3; ae_thr = 3'd3; init = 1'b1; fifo_error = 5'b00010;
    tick();
    init = 1'b0; fifo_error = '0;
    n_tests++;
    if (state_out !== 5'b00010 || pause_out !== '0) begin
      n_fail++; $display("FAIL error_init_wins: state=%b pause=%b want 00010/00000", state_out, pause_out);
    end
    tick();
    n_tests++;
    if (state_out !== 5'b10000 || cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_err_set: state=%b cfg=%b want 10000/1", state_out, cfg_err);
    end
    af_thr = 3'd6; ae_thr = 3'd1; init = 1'b1;
    tick();
    init = 1'b0;
    n_tests++;
    if (state_out !== 5'b00010) begin n_fail++; $display("FAIL cfg_reinit: got %b want 00010", state_out); end
    tick();
    n_tests++;
    if (state_out !== 5'b00100 || cfg_err !== 1'b0 || error_out !== '0) begin
      n_fail++; $display("FAIL cfg_clear: state=%b cfg=%b err=%b want 00100/0/00000", state_out, cfg_err, error_out);
    end
  endtask

  task automatic test_async_reset();
    fifo_empty = 5'b11110;
    fifo_count[W-1:0] = 3'd7;
    tick();
    n_tests++;
    if (state_out !== 5'b01000 || pause_out[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_active: state=%b pause=%b want 01000/bit0=1", state_out, pause_out);
    end
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (state_out !== 5'b00001 || {error_out, cfg_err, idle_out, active_out, pause_out} !== '0) begin
      n_fail++; $display("FAIL async_reset: state=%b err=%b cfg=%b idle=%b act=%b pause=%b want 00001 and zeros",
                         state_out, error_out, cfg_err, idle_out, active_out, pause_out);
    end
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    n_tests++;
    if (state_out !== 5'b00001) begin n_fail++; $display("FAIL release_hold: got %b want 00001", state_out); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      init       = ($urandom_range(0, 5) == 0);
      fifo_error = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      fifo_empty = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
      fifo_count = (N*W)'($urandom);
      af_thr     = W'($urandom);
      ae_thr     = W'($urandom);
      tick();
      n_tests++;
      if (state_out !== 5'(1 << m_st)) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got %b want %b", k, state_out, 5'(1 << m_st));
      end
      n_tests++;
      if (error_out !== m_err || cfg_err !== m_cfg) begin
        n_fail++; $display("FAIL rnd_err[%0d]: err=%b cfg=%b want %b/%b", k, error_out, cfg_err, m_err, m_cfg);
      end
      n_tests++;
      if (idle_out !== (m_st == 2) || active_out !== (m_st == 3)) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: idle=%b act=%b want %b/%b", k, idle_out, active_out, m_st == 2, m_st == 3);
      end
      n_tests++;
      if (pause_out !== m_pause) begin
        n_fail++; $display("FAIL rnd_pause[%0d]: got %b want %b", k, pause_out, m_pause);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_seq();
    test_idle_active();
    test_pause_hyst();
    test_error_sticky();
    test_cfg_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
